sync_inverter_bank: RTL
=======================

// Module: sync_inverter_bank
// PURPOSE
//  Multi-channel registered inverter for asynchronous pad inputs.
//  Each of WIDTH channels runs through a synchroniser, an optional glitch filter,
//  and a runtime-programmable polarity (invert or pass) stage.
//  Outputs are registered, with one-cycle rise/fall pulses per channel.
//  Sits between top-level async inputs and core logic; replaces single-bit inverters.
// PARAMETERS
//  WIDTH          8          number of independent channels (>=1)
//  SYNC_STAGES    2          synchroniser flops per channel (>=2)
//  FILTER_CYCLES  4          consecutive cycles a new level must persist when filtering (>=1)
//  INIT_POL       {WIDTH{1}} polarity register reset value; 1 = invert
// PORTS
//  clk          in   1      single clock; all state on rising edge
//  reset_n      in   1      asynchronous assert, active-low reset
//  in           in   WIDTH  asynchronous channel inputs
//  invert_mask  in   WIDTH  new polarity value, sampled when load_mask=1
//  load_mask    in   1      load invert_mask into polarity register this edge
//  filter_en    in   1      1 = glitch filter active; 0 = bypass
//  out          out  WIDTH  registered result: filt ^ pol
//  rise         out  WIDTH  1-cycle pulse, coincident with out 0->1
//  fall         out  WIDTH  1-cycle pulse, coincident with out 1->0
//  stable       out  WIDTH  1 when synced input == filtered level and counter idle
// BEHAVIOUR
//  Reset (reset_n=0, async) sets:
//  - sync flops = 0, filt = 0, cnt = 0, pol = INIT_POL
//  - out = INIT_POL, rise = fall = 0
//  Synchroniser: s = last stage of a SYNC_STAGES-deep shift chain on in[i].
//  Filter, per channel; cnt width = $clog2(FILTER_CYCLES)+1:
//  - filter_en=0: filt <= s; cnt <= 0 every cycle
//  - filter_en=1, s==filt: cnt <= 0
//  - filter_en=1, s!=filt, cnt==FILTER_CYCLES-1: filt <= s; cnt <= 0
//  - filter_en=1, s!=filt, otherwise: cnt <= cnt+1
//  - Any cycle with s==filt restarts the count, so glitches shorter than FILTER_CYCLES never pass.
//  - filter_en dropping mid-count clears cnt; filt follows s on the next edge.
//  Polarity:
//  - load_mask=1: pol <= invert_mask at the edge.
//  - out reflects the new pol one edge later.
//  Output stage:
//  - out  <= filt ^ pol
//  - rise <= (filt^pol) & ~out
//  - fall <= ~(filt^pol) & out
//  - A polarity change that flips out also produces rise/fall.
//  stable[i] = (s==filt) & (cnt==0), combinational from flops.
//  Latency from in edge to out, with in held stable:
//  - SYNC_STAGES + FILTER_CYCLES + 1 cycles (filter on)
//  - SYNC_STAGES + 2 cycles (filter off)
//  Channels are fully independent; simultaneous events on different channels do not interact.
//  A load_mask edge coinciding with a filt update: out uses the old pol that edge, the new pol the next.
//  Reset asserted mid-count discards all in-flight state.
// TESTING
//  1. Reset, all defaults, in=0
//     -> out=8'hFF, rise=fall=0, stable=8'hFF.
//  2. filter_en=0, in[0] 0->1 held
//     -> out[0] goes 1->0 exactly 4 edges later; fall[0]=1 for 1 cycle.
//  3. filter_en=1, in[3] high for 3 cycles then low
//     -> out[3] never changes, no pulses.
//  4. filter_en=1, in[3] high held
//     -> out[3] falls 7 edges after input change.
//  5. in=0, load_mask=1 with invert_mask=8'h0F
//     -> next edge pol=8'h0F; following edge out=8'h0F, fall=8'hF0 for 1 cycle.
//  6. Reset asserted mid-count (cnt=2) on ch5
//     -> out=INIT_POL immediately; after release, ch5 requires a full 4-cycle persistence.

Source files
------------

// File: rtl/sync_inverter_bank.sv
// sync_inverter_bank
// Multi-channel conditioner for asynchronous pad inputs. Each channel is
// synchronised, optionally glitch filtered, then passed or inverted by a
// programmable polarity bit. The result is registered, with one-cycle
// rise/fall pulses and a combinational per-channel "stable" flag.

module sync_inverter_bank #(
   parameter int               WIDTH         = 8,
   parameter int               SYNC_STAGES   = 2,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] INIT_POL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] invert_mask,
   input  logic             load_mask,
   input  logic             filter_en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] stable
);

   localparam int            CW       = $clog2(FILTER_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] filt_q, filt_d;
   logic [WIDTH-1:0] pol_q,  pol_d;
   logic [WIDTH-1:0] out_q,  out_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift chain: stage 0 captures the raw pad value.
   always_comb begin
      sync_d[0] = in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Glitch filter: a new level is accepted only after it has been seen on
   // FILTER_CYCLES consecutive edges; any agreeing cycle restarts the count.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (!filter_en) begin
            filt_d[i] = s[i];
         end else if (s[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               filt_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Polarity register and output stage; out uses the polarity held before this edge.
   always_comb begin
      pol_d  = load_mask ? invert_mask : pol_q;
      out_d  = filt_q ^ pol_q;
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   // Stable means the synced input agrees with the filtered level and no count is pending.
   always_comb begin
      stable = '0;
      for (int i = 0; i < WIDTH; i++) begin
         stable[i] = (s[i] == filt_q[i]) && (cnt_q[i] == '0);
      end
   end

   // State registers; reset discards all in-flight synchroniser and filter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         filt_q <= '0;
         pol_q  <= INIT_POL;
         out_q  <= INIT_POL;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         filt_q <= filt_d;
         pol_q  <= pol_d;
         out_q  <= out_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign out  = out_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule
